// File: rtl/fa_4bit_serial_sub_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
// The requester drives start/a/b/bi and the subtractor drives busy/done/diff/bo.
interface fa_4bit_serial_sub_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bo;

    modport master (
        output start, a, b, bi,
        input  busy, done, diff, bo
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, diff, bo
    );
endinterface

// File: rtl/fa_4bit_serial_sub.sv
// Bit-serial subtractor: diff = a - b - bi, LSB first, one full-subtractor cell per clock.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to 0 on underflow (bo still reports the borrow).
module fa_4bit_serial_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    fa_4bit_serial_sub_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bo_q, bo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               d_bit;
    logic               br_next;
    logic [WIDTH-1:0]   res_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bo_d     = bo_q;

        // Full-subtractor cell on the current LSBs of the shifting operands
        d_bit    = a_q[0] ^ b_q[0] ^ br_q;
        br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_next = {d_bit, res_q[WIDTH-1:1]};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bi;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_SUB_SAT_EN
                    diff_d = br_next ? '0 : res_next;
`else
                    diff_d = res_next;
`endif
                    bo_d    = br_next;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bo   = bo_q;
endmodule

// File: tb/tb_fa_4bit_serial_sub.sv
// Self-checking bench for fa_4bit_serial_sub (WIDTH=4) against an arithmetic reference model.
// Build with +define+SERIAL_SUB_SAT_EN to check the saturating variant.
module tb_fa_4bit_serial_sub;
    localparam int unsigned W   = 4;
    localparam int          LAT = W + 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fa_4bit_serial_sub_if #(.WIDTH(W)) bus ();

    fa_4bit_serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction, wrapped to W bits
    function automatic void model(input int a, input int b, input int bi,
                                  output logic [W-1:0] d, output logic bo);
        int r;
        r  = a - b - bi;
        bo = (r < 0);
        d  = W'(r);
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = '0;
`endif
    endfunction

    // Starts an operation at a post-edge point and waits (bounded) for done.
    // Returns latency in cycles (0 = timeout) plus protocol-violation flags.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output int lat, output logic [W-1:0] d, output logic bo,
                         output bit bad_busy, output bit overlap, output bit early);
        logic [W-1:0] prev;
        prev     = bus.diff;
        lat      = 0;
        bad_busy = 0;
        overlap  = 0;
        early    = 0;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bi    = bi;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bi    = 1'($urandom);
        for (int k = 1; k <= 20; k++) begin
            if (bus.busy && bus.done) overlap = 1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) bad_busy = 1;
            if (bus.diff !== prev) early = 1;
            @(posedge clk); #1;
        end
        d  = bus.diff;
        bo = bus.bo;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bo} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b diff=%0d bo=%b, required all 0",
                     bus.busy, bus.done, bus.diff, bus.bo);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{4'd9, 4'd3, 4'd0, 4'd15};
        logic [W-1:0] vb [4] = '{4'd3, 4'd5, 4'd0, 4'd15};
        logic         vi [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat; logic [W-1:0] d, ed; logic bo, ebo; bit bb, ov, ea;
        for (int i = 0; i < 4; i++) begin
            model(int'(va[i]), int'(vb[i]), int'(vi[i]), ed, ebo);
            do_op(va[i], vb[i], vi[i], lat, d, bo, bb, ov, ea);
            checks++;
            if (lat != LAT || bb || ov || ea) begin
                errors++;
                $display("FAIL directed_timing[%0d]: latency=%0d busy_gap=%0d overlap=%0d early_diff=%0d, required latency=%0d and no flags",
                         i, lat, bb, ov, ea, LAT);
            end
            checks++;
            if (d !== ed || bo !== ebo) begin
                errors++;
                $display("FAIL directed_result[%0d]: %0d-%0d-%0d got diff=%0d bo=%b, required diff=%0d bo=%b",
                         i, va[i], vb[i], vi[i], d, bo, ed, ebo);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.diff !== ed || bus.bo !== ebo) begin
                errors++;
                $display("FAIL directed_hold[%0d]: done=%b diff=%0d bo=%b, required done=0 diff=%0d bo=%b",
                         i, bus.done, bus.diff, bus.bo, ed, ebo);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, dones; logic [W-1:0] d; logic bo; bit bb, ov, ea;
        dones = 0;
        lat   = 0;
        bus.start = 1'b1; bus.a = 4'd8; bus.b = 4'd1; bus.bi = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                bus.start = 1'b1; bus.a = 4'd0; bus.b = 4'd0; bus.bi = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dones++;
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 1 || lat != LAT || bus.diff !== 4'd7 || bus.bo !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: dones=%0d latency=%0d diff=%0d bo=%b, required 1 %0d 7 0",
                     dones, lat, bus.diff, bus.bo, LAT);
        end
        // Start issued in the DONE cycle must be accepted
        do_op(4'd4, 4'd4, 1'b0, lat, d, bo, bb, ov, ea);
        checks++;
        if (lat != LAT || d !== 4'd0 || bo !== 1'b0 || bb || ov || ea) begin
            errors++;
            $display("FAIL back_to_back_in_done: latency=%0d diff=%0d bo=%b flags=%0d%0d%0d, required %0d 0 0 000",
                     lat, d, bo, bb, ov, ea, LAT);
        end
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL no_extra_done: got %0d done pulses, required 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        int lat, dones; logic [W-1:0] d; logic bo; bit bb, ov, ea;
        do_op(4'd3, 4'd5, 1'b0, lat, d, bo, bb, ov, ea);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.bi = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bo} !== '0) begin
            errors++;
            $display("FAIL reset_mid_shift: busy=%b done=%b diff=%0d bo=%b, required all 0",
                     bus.busy, bus.done, bus.diff, bus.bo);
        end
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d cycles with busy/done after abort, required 0", dones);
        end
    endtask

    task automatic test_sweep();
        int lat; logic [W-1:0] d, ed; logic bo, ebo; bit bb, ov, ea;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    model(a, b, bi, ed, ebo);
                    do_op(W'(a), W'(b), 1'(bi), lat, d, bo, bb, ov, ea);
                    checks++;
                    if (lat != LAT || bb || ov || ea || d !== ed || bo !== ebo) begin
                        errors++;
                        $display("FAIL sweep: %0d-%0d-%0d got diff=%0d bo=%b lat=%0d flags=%0d%0d%0d, required diff=%0d bo=%b lat=%0d",
                                 a, b, bi, d, bo, lat, bb, ov, ea, ed, ebo, LAT);
                    end
                end
            end
        end
    endtask

    task automatic test_random_gaps();
        int lat, a, b, bi, gap; logic [W-1:0] d, ed; logic bo, ebo; bit bb, ov, ea;
        for (int i = 0; i < 60; i++) begin
            a   = int'($urandom_range(15, 0));
            b   = int'($urandom_range(15, 0));
            bi  = int'($urandom_range(1, 0));
            gap = int'($urandom_range(2, 0));
            repeat (gap) begin
                @(posedge clk); #1;
            end
            model(a, b, bi, ed, ebo);
            do_op(W'(a), W'(b), 1'(bi), lat, d, bo, bb, ov, ea);
            checks++;
            if (lat != LAT || bb || ov || ea || d !== ed || bo !== ebo) begin
                errors++;
                $display("FAIL random[%0d]: %0d-%0d-%0d gap=%0d got diff=%0d bo=%b lat=%0d, required diff=%0d bo=%b lat=%0d",
                         i, a, b, bi, gap, d, bo, lat, ed, ebo, LAT);
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bi    = 1'b0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_sweep();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
